conv_axi_lite_regs: RTL

AXI4-Lite slave register bank for the convolution IP. It terminates the s00 AXI-Lite bus and exposes control and configuration to the core: start pulse, image size, kernel size and interrupt enable. It also collects status from the core: ready and a sticky done flag. It sits directly downstream of the s00 AXI-Lite bus and upstream of the conv core control inputs.

---
 rtl/conv_axi_lite_regs.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_axi_lite_regs.sv
// rtl/conv_axi_lite_regs.sv - AXI4-Lite register bank (CMD/STATUS/IMG_SIZE/KER_SIZE/IRQ_EN) for the conv core
//
// Ports:
//   clk, reset (async, active-low)
//   s00_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave (awprot/arprot ignored)
//   core_ready_i, core_done_i  status from the conv core
//   start_o                    one-cycle start pulse to the core
//   img_size_o, ker_size_o     size configuration
//   irq_o                      level interrupt
//
// Build option: CONV_AXI_LITE_IRQ_EN enables the IRQ_EN register and irq_o.
// Without it, irq_o is tied low and IRQ_EN reads 0 / ignores writes.
//
// Map (word index = addr[4:2]): 0 CMD, 1 STATUS, 2 IMG_SIZE, 3 KER_SIZE,
// 4 IRQ_EN, 5..7 unmapped (SLVERR).

module conv_axi_lite_regs #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5,
    parameter int SIZE                 = 10,
    parameter int SIZE_KERNEL          = 5,
    parameter int CFG_W                = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic                                core_ready_i,
    input  logic                                core_done_i,
    output logic                                start_o,
    output logic [CFG_W-1:0]                    img_size_o,
    output logic [CFG_W-1:0]                    ker_size_o,
    output logic                                irq_o
);

    localparam int DW    = C_S00_AXI_DATA_WIDTH;
    localparam int SW    = C_S00_AXI_DATA_WIDTH / 8;
    localparam int AW    = C_S00_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW - 2;

    localparam logic [IDX_W-1:0] A_CMD    = IDX_W'(0);
    localparam logic [IDX_W-1:0] A_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] A_IMG    = IDX_W'(2);
    localparam logic [IDX_W-1:0] A_KER    = IDX_W'(3);
    localparam logic [IDX_W-1:0] A_IRQEN  = IDX_W'(4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge of a write into a size register, then clamp 0 -> 1.
    function automatic logic [CFG_W-1:0] f_size_wr(input logic [CFG_W-1:0] old_v,
                                                   input logic [DW-1:0]    d,
                                                   input logic [SW-1:0]    s);
        logic [CFG_W-1:0] m;
        for (int i = 0; i < CFG_W; i++) begin
            m[i] = s[i/8] ? d[i] : old_v[i];
        end
        f_size_wr = (m == '0) ? CFG_W'(1) : m;
    endfunction

    // Write channel state
    logic             r_live;       // low only in the first cycle after reset release
    logic             r_aw_held;
    logic [IDX_W-1:0] r_aw_idx;
    logic             r_w_held;
    logic [DW-1:0]    r_wdata;
    logic [SW-1:0]    r_wstrb;
    logic             r_bvalid;
    logic [1:0]       r_bresp;

    // Read channel state
    logic             r_rvalid;
    logic [1:0]       r_rresp;
    logic [DW-1:0]    r_rdata;

    // Register file and core-facing state
    logic [CFG_W-1:0] r_img;
    logic [CFG_W-1:0] r_ker;
    logic             r_done;
    logic             r_err;
    logic             r_start;
`ifdef CONV_AXI_LITE_IRQ_EN
    logic             r_irq_en;
    logic             r_irq;
`endif

    logic             w_awready, w_wready, w_arready;
    logic             w_aw_hs, w_w_hs, w_ar_hs;
    logic             w_commit;
    logic [IDX_W-1:0] w_widx, w_ridx;
    logic [DW-1:0]    w_wd;
    logic [SW-1:0]    w_ws;
    logic             w_cmd_wr, w_start_req, w_clr_done, w_clr_err;
    logic             w_wr_mapped;
    logic [DW-1:0]    w_rd_data;
    logic [1:0]       w_rd_resp;
    logic             w_irq_en_q;
    logic             w_unused_ok;

    assign w_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_live & ~r_w_held  & ~r_bvalid;
    assign w_arready = r_live & ~r_rvalid;

    assign w_aw_hs = s00_axi_awvalid & w_awready;
    assign w_w_hs  = s00_axi_wvalid  & w_wready;
    assign w_ar_hs = s00_axi_arvalid & w_arready;

    // Commit on the edge where the second of the two beats is captured
    // (or both at once); the held copy is used for whichever came first.
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_widx   = r_aw_held ? r_aw_idx : s00_axi_awaddr[AW-1:2];
    assign w_wd     = r_w_held  ? r_wdata  : s00_axi_wdata;
    assign w_ws     = r_w_held  ? r_wstrb  : s00_axi_wstrb;

    assign w_wr_mapped = (w_widx <= A_IRQEN);
    assign w_cmd_wr    = w_commit & (w_widx == A_CMD) & w_ws[0];
    assign w_start_req = w_cmd_wr & w_wd[0];
    // A start write also clears the done flag.
    assign w_clr_done  = w_cmd_wr & (w_wd[1] | w_wd[0]);
    assign w_clr_err   = w_cmd_wr & w_wd[2];

    assign w_ridx = s00_axi_araddr[AW-1:2];

`ifdef CONV_AXI_LITE_IRQ_EN
    assign w_irq_en_q = r_irq_en;
`else
    assign w_irq_en_q = 1'b0;
`endif

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ridx)
            A_CMD:    w_rd_data = '0;
            A_STATUS: w_rd_data = DW'({r_err, r_done, core_ready_i});
            A_IMG:    w_rd_data = DW'(r_img);
            A_KER:    w_rd_data = DW'(r_ker);
            A_IRQEN:  w_rd_data = DW'(w_irq_en_q);
            default:  w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Write channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= s00_axi_awaddr[AW-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s00_axi_wdata;
                    r_wstrb  <= s00_axi_wstrb;
                end
                if (r_bvalid && s00_axi_bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // Read channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_resp;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Configuration registers and core handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_img   <= CFG_W'(SIZE);
            r_ker   <= CFG_W'(SIZE_KERNEL);
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
        end else begin
            if (w_commit && w_widx == A_IMG) r_img <= f_size_wr(r_img, w_wd, w_ws);
            if (w_commit && w_widx == A_KER) r_ker <= f_size_wr(r_ker, w_wd, w_ws);

            r_start <= w_start_req & core_ready_i;

            // Set has priority over clear for both sticky flags.
            if (core_done_i)     r_done <= 1'b1;
            else if (w_clr_done) r_done <= 1'b0;

            if (w_start_req && !core_ready_i) r_err <= 1'b1;
            else if (w_clr_err)               r_err <= 1'b0;
        end
    end

`ifdef CONV_AXI_LITE_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_commit && w_widx == A_IRQEN && w_ws[0]) r_irq_en <= w_wd[0];
            r_irq <= r_irq_en & r_done;
        end
    end
    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    assign s00_axi_awready = w_awready;
    assign s00_axi_wready  = w_wready;
    assign s00_axi_arready = w_arready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;
    assign start_o         = r_start;
    assign img_size_o      = r_img;
    assign ker_size_o      = r_ker;

    assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], w_wd};

endmodule
